// File: rtl/iter_divider.sv
// iter_divider: radix-2 restoring divider for MIPS DIV/DIVU with busy/done handshake.
module iter_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             div_cancel,
  output logic             DIV_Busy,
  output logic             div_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, q, dvs;
  logic             q_neg, r_neg, dz;
  logic [WIDTH:0]   shifted, diff;
  logic             ok;
  always_comb begin
    shifted = {rem, q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    ok      = !diff[WIDTH];
  end
  // On divide-by-zero the raw dividend is latched so the restoring loop returns it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      q         <= '0;
      dvs       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz        <= 1'b0;
      DIV_Busy  <= 1'b0;
      div_done  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (div_cancel) begin
      state    <= IDLE;
      DIV_Busy <= 1'b0;
      div_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_done <= 1'b0;
          if (div_start) begin
            state    <= CALC;
            DIV_Busy <= 1'b1;
            cnt      <= '0;
            rem      <= '0;
            dz       <= divisor == '0;
            dvs      <= (div_signed && divisor[WIDTH-1]) ? -divisor : divisor;
            q        <= (divisor != '0 && div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            q_neg    <= div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg    <= div_signed && dividend[WIDTH-1];
          end
        end
        CALC: begin
          rem   <= ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          q     <= {q[WIDTH-2:0], ok};
          cnt   <= cnt + 1'b1;
          state <= (cnt == CNT_W'(WIDTH - 1)) ? FIX : CALC;
        end
        FIX: begin
          quotient  <= (q_neg && !dz) ? -q : q;
          remainder <= (r_neg && !dz) ? -rem : rem;
          DIV_Busy  <= 1'b0;
          div_done  <= 1'b1;
          state     <= DONE;
        end
        default: begin
          div_done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: randomized scoreboard bench for iter_divider against an arithmetic reference.
module tb_iter_divider;
  logic        clk = 0, rst = 0;
  logic        div_start = 0, div_signed = 0, div_cancel = 0;
  logic [31:0] dividend = 0, divisor = 0;
  logic        DIV_Busy, div_done;
  logic [31:0] quotient, remainder;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = 0;
  int n_checks = 0, n_fail = 0;

  iter_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .div_start(div_start), .div_signed(div_signed),
    .dividend(dividend), .divisor(divisor), .div_cancel(div_cancel),
    .DIV_Busy(DIV_Busy), .div_done(div_done), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, lq, lr;
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (!s) return {a / b, a % b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lq = sa / sb;
    lr = sa % sb;
    return {lq[31:0], lr[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial forever begin
    @(posedge clk);
    #1;
    if (div_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        last_res = exp_q.pop_front();
        check("quotient", {32'd0, quotient}, {32'd0, last_res[63:32]});
        check("remainder", {32'd0, remainder}, {32'd0, last_res[31:0]});
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic cancel);
    @(negedge clk);
    dividend = a; divisor = b; div_signed = s; div_start = 1; div_cancel = cancel;
    @(posedge clk);
    #1;
    div_start = 0; div_cancel = 0;
    dividend = $urandom; divisor = $urandom; div_signed = 1'($urandom);
  endtask

  // Full operation with latency checks; inject > 0 drives an extra start that must be ignored.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s, input int inject);
    logic [31:0] q0, r0;
    logic bad;
    q0 = quotient; r0 = remainder; bad = 0;
    exp_q.push_back(model(a, b, s));
    issue(a, b, s, 0);
    check("busy_e0", {63'd0, DIV_Busy}, 64'd1);
    for (int k = 1; k <= 32; k++) begin
      if (k == inject) begin div_start = 1; dividend = 9; divisor = 3; div_signed = 0; end
      @(posedge clk);
      #1;
      div_start = 0;
      if (!DIV_Busy || div_done || quotient !== q0 || remainder !== r0) bad = 1;
    end
    check("busy_hold_no_early_result", {63'd0, bad}, 64'd0);
    @(posedge clk);
    #1;
    check("busy_low_done_high", {62'd0, DIV_Busy, div_done}, 64'd1);
    @(posedge clk);
    #1;
    check("done_one_cycle", {62'd0, DIV_Busy, div_done}, 64'd0);
  endtask

  initial begin
    #12;
    check("reset_state", {DIV_Busy, div_done, 30'd0, quotient ^ remainder}, 64'd0);
    check("reset_q", {32'd0, quotient}, 64'd0);
    @(negedge clk);
    rst = 1;
    run(100, 7, 0, 0);
    run(32'hFFFF_FFF9, 2, 1, 0);
    run(7, 32'hFFFF_FFFE, 1, 0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    run(32'h1234_5678, 0, 0, 0);
    run(32'h8765_4321, 0, 1, 0);
    run(32'hFFFF_FFFF, 1, 0, 0);
    run(1000, 7, 0, 10);
    run(9, 3, 0, 0);
    // Cancel mid-CALC: busy drops, no done, outputs hold.
    issue(500, 3, 0, 0);
    repeat (15) @(posedge clk);
    #1;
    div_cancel = 1;
    @(posedge clk);
    #1;
    div_cancel = 0;
    check("cancel_busy", {63'd0, DIV_Busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("cancel_hold", {quotient, remainder}, last_res);
    // Start together with cancel in IDLE is dropped.
    issue(77, 5, 0, 1);
    check("start_cancel_idle", {63'd0, DIV_Busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("start_cancel_hold", {quotient, remainder}, last_res);
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      logic s;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
      s = 1'($urandom);
      run(a, b, s, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    // Async reset mid-CALC.
    issue(12345, 11, 1, 0);
    repeat (19) @(posedge clk);
    #1;
    rst = 0;
    #1;
    check("reset_mid_calc", {DIV_Busy, div_done, 62'd0}, 64'd0);
    check("reset_mid_results", {quotient, remainder}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1;
    run(50, 5, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
